// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nn_pkg
//  Purpose  : Shared types and defaults for the result collector slice
//  Revision : 1.0  initial release
// ============================================================================
package nn_pkg;

  // Default result width across the accelerator output path
  localparam int NN_DATA_W = 16;

  // Collector state: gathering a frame, or holding a finished frame for ack
  typedef enum logic [0:0] {
    ST_COLLECT = 1'b0,
    ST_DONE    = 1'b1
  } coll_state_t;

endpackage
`default_nettype wire

// File: rtl/nn_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : nn_sync_fifo
//  Purpose  : Single-clock first-word-fall-through FIFO with occupancy count
//  Revision : 1.0  initial release
// ============================================================================
module nn_sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_wr_en,
  input  logic [DATA_W-1:0]          i_wr_data,
  input  logic                       i_rd_en,
  output logic [DATA_W-1:0]          o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  // Writes into a full FIFO and reads from an empty one are dropped here
  assign w_push  = i_wr_en & ~w_full;
  assign w_pop   = i_rd_en & ~w_empty;

  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_count   = r_count;
  // Head shows zero while empty so the output is defined straight out of reset
  assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];

  // Storage array: written on every accepted push, never reset
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers wrap naturally (power-of-two depth); count tracks pushes minus pops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/nn_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : nn_result_collector
//  Purpose  : Accepts accelerator results, buffers them for the host and
//             reports the per-frame argmax; stalls input until frame ack
//  Revision : 1.0  initial release
// ============================================================================
module nn_result_collector
  import nn_pkg::*;
#(
  parameter int DATA_W    = NN_DATA_W,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           in_valid,
  input  logic [DATA_W-1:0]              in_data,
  output logic                           in_ready,
  input  logic                           rd_en,
  output logic                           rd_valid,
  output logic [DATA_W-1:0]              rd_data,
  output logic [$clog2(DEPTH):0]         fifo_count,
  output logic                           frame_done,
  input  logic                           frame_ack,
  output logic [$clog2(FRAME_LEN)-1:0]   argmax_idx,
  output logic [DATA_W-1:0]              argmax_val
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(FRAME_LEN - 1);

  coll_state_t        r_state;
  logic [IDX_W-1:0]   r_item_cnt;
  logic [DATA_W-1:0]  r_run_val;
  logic [IDX_W-1:0]   r_run_idx;
  logic [IDX_W-1:0]   r_am_idx;
  logic [DATA_W-1:0]  r_am_val;

  logic               w_full;
  logic               w_empty;
  logic               w_accept;
  logic               w_take;
  logic [DATA_W-1:0]  w_new_val;
  logic [IDX_W-1:0]   w_new_idx;

  assign in_ready   = (r_state == ST_COLLECT) & ~w_full;
  assign w_accept   = in_valid & in_ready;
  assign rd_valid   = ~w_empty;
  assign frame_done = (r_state == ST_DONE);
  assign argmax_idx = r_am_idx;
  assign argmax_val = r_am_val;

  // First item of a frame always seeds the running max; later ones need a
  // strictly greater signed value, so ties stay at the lowest index
  assign w_take    = (r_item_cnt == '0) | ($signed(in_data) > $signed(r_run_val));
  assign w_new_val = w_take ? in_data    : r_run_val;
  assign w_new_idx = w_take ? r_item_cnt : r_run_idx;

  nn_sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_accept),
    .i_wr_data (in_data),
    .i_rd_en   (rd_en),
    .o_rd_data (rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (fifo_count)
  );

  // Frame FSM with item counter and running argmax; published argmax is
  // captured on the transition into DONE and held until the next frame ends
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= ST_COLLECT;
      r_item_cnt <= '0;
      r_run_val  <= '0;
      r_run_idx  <= '0;
      r_am_idx   <= '0;
      r_am_val   <= '0;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_accept) begin
            r_run_val <= w_new_val;
            r_run_idx <= w_new_idx;
            if (r_item_cnt == c_LAST) begin
              r_item_cnt <= '0;
              r_am_val   <= w_new_val;
              r_am_idx   <= w_new_idx;
              r_state    <= ST_DONE;
            end else begin
              r_item_cnt <= r_item_cnt + IDX_W'(1);
            end
          end
        end
        ST_DONE: begin
          if (frame_ack) r_state <= ST_COLLECT;
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nn_result_collector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nn_result_collector
//  Purpose  : Self-checking bench for nn_result_collector
//  Revision : 1.0  initial release
// ============================================================================
module tb_nn_result_collector;

  localparam int DATA_W    = 16;
  localparam int DEPTH     = 8;
  localparam int FRAME_LEN = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              rd_en = 1'b0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [3:0]        fifo_count;
  logic              frame_done;
  logic              frame_ack = 1'b0;
  logic [3:0]        argmax_idx;
  logic [DATA_W-1:0] argmax_val;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DATA_W-1:0] q[$];
  int                fr[$];
  bit                m_done = 1'b0;
  int                m_am_idx = 0;
  int                m_am_val = 0;

  always #5 clk = ~clk;

  nn_result_collector #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .FRAME_LEN (FRAME_LEN)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .rd_en      (rd_en),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fifo_count (fifo_count),
    .frame_done (frame_done),
    .frame_ack  (frame_ack),
    .argmax_idx (argmax_idx),
    .argmax_val (argmax_val)
  );

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor + scoreboard: mid-cycle sampling, inputs only change just after posedge
  always @(negedge clk) begin
    bit exp_ready;
    int best;
    if (reset) begin
      q.delete();
      fr.delete();
      m_done   = 1'b0;
      m_am_idx = 0;
      m_am_val = 0;
      chk("rst_in_ready",   in_ready,   1);
      chk("rst_rd_valid",   rd_valid,   0);
      chk("rst_rd_data",    rd_data,    0);
      chk("rst_fifo_count", fifo_count, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_argmax_idx", argmax_idx, 0);
      chk("rst_argmax_val", $signed(argmax_val), 0);
    end else begin
      exp_ready = !m_done && (q.size() < DEPTH);
      chk("frame_done", frame_done, m_done);
      chk("in_ready",   in_ready,   exp_ready);
      chk("rd_valid",   rd_valid,   q.size() > 0);
      chk("fifo_count", fifo_count, q.size());
      chk("argmax_idx", argmax_idx, m_am_idx);
      chk("argmax_val", $signed(argmax_val), m_am_val);
      if (q.size() > 0) chk("rd_data", rd_data, q[0]);
      if (rd_en && q.size() > 0) void'(q.pop_front());
      if (in_valid && exp_ready) begin
        q.push_back(in_data);
        fr.push_back(int'($signed(in_data)));
        if (fr.size() == FRAME_LEN) begin
          best = 0;
          for (int i = 1; i < FRAME_LEN; i++) if (fr[i] > fr[best]) best = i;
          m_am_idx = best;
          m_am_val = fr[best];
          fr.delete();
          m_done = 1'b1;
        end
      end else if (m_done && frame_ack) begin
        m_done = 1'b0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input int v);
    int n = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'(v);
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!frame_done && n < 30) begin
      tick(1);
      n++;
    end
    chk("wait_frame_done", frame_done, 1);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    tick(1);
    frame_ack = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    rd_en = 1'b1;
    while (fifo_count != 0 && n < 40) begin
      tick(1);
      n++;
    end
    rd_en = 1'b0;
    chk("drain_empty", fifo_count, 0);
  endtask

  int frame_a[FRAME_LEN] = '{3, -1, 7, 2, 7, 0, -5, 6, 1, 4};
  int frame_n[FRAME_LEN] = '{-9, -8, -7, -6, -5, -4, -3, -2, -1, -20};

  initial begin
    tick(3);
    reset = 1'b0;
    tick(1);

    // Tie frame, host draining continuously
    rd_en = 1'b1;
    foreach (frame_a[i]) send(frame_a[i]);
    wait_done();
    chk("tie_idx", argmax_idx, 2);
    chk("tie_val", $signed(argmax_val), 7);
    ack();
    chk("ack_ready", in_ready, 1);
    rd_en = 1'b0;

    // Reset in the middle of a frame
    for (int i = 0; i < 4; i++) send(10 + i);
    reset = 1'b1;
    #1;
    chk("async_rst_count", fifo_count, 0);
    chk("async_rst_argmax_val", $signed(argmax_val), 0);
    chk("async_rst_ready", in_ready, 1);
    tick(2);
    reset = 1'b0;
    tick(1);

    // All-negative frame: signed comparison, counter restarted at 0
    rd_en = 1'b1;
    foreach (frame_n[i]) send(frame_n[i]);
    wait_done();
    chk("neg_idx", argmax_idx, 8);
    chk("neg_val", $signed(argmax_val), -1);
    ack();
    drain();

    // Fill the FIFO without reads
    for (int i = 0; i < DEPTH; i++) send(100 + i);
    chk("full_count", fifo_count, 8);
    chk("full_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 16'd99;
    tick(3);
    chk("full_no_overwrite", fifo_count, 8);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(1);
    in_valid = 1'b0;
    chk("ninth_accepted", fifo_count, 8);
    drain();
    send(5);
    wait_done();

    // Input held off while DONE
    in_valid = 1'b1;
    in_data  = 16'd55;
    tick(5);
    chk("done_no_accept", fifo_count, 1);
    chk("done_ready_low", in_ready, 0);
    in_valid = 1'b0;
    ack();
    chk("ack_ready2", in_ready, 1);
    chk("ack_done_clear", frame_done, 0);

    // Read from empty, then push+pop at count 3
    drain();
    rd_en = 1'b1;
    tick(3);
    rd_en = 1'b0;
    chk("empty_rd_valid", rd_valid, 0);
    chk("empty_count", fifo_count, 0);
    for (int i = 0; i < 3; i++) send(20 + i);
    chk("count3", fifo_count, 3);
    in_valid = 1'b1;
    in_data  = 16'd77;
    rd_en    = 1'b1;
    tick(1);
    in_valid = 1'b0;
    rd_en    = 1'b0;
    chk("pushpop_count3", fifo_count, 3);

    // Randomized traffic against the reference model
    for (int c = 0; c < 500; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4)) : 16'($urandom);
      rd_en     = ($urandom_range(0, 2) == 0);
      frame_ack = ($urandom_range(0, 3) == 0);
      tick(1);
    end
    in_valid  = 1'b0;
    frame_ack = 1'b1;
    tick(2);
    frame_ack = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
